emulador_hcsr04: RTL and testbench

Synthesizable emulator of the sensor end of the HC-SR04 trigger/echo protocol. It watches `trigger`, validates the pulse width, waits a fixed burst delay, then drives `echo` high for a duration proportional to a BCD distance input, at 58.82 us/cm. It lets the range-measuring system and its serial reporting be exercised on the board or in regression without a physical sensor.

---
 rtl/emulador_hcsr04_pkg.sv | 26 ++
 rtl/emulador_hcsr04_if.sv | 22 ++
 rtl/emulador_hcsr04_bcd_para_binario.sv | 20 ++
 rtl/emulador_hcsr04.sv | 146 ++++++++++++++
 tb/tb_emulador_hcsr04.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/emulador_hcsr04_pkg.sv
// Shared definitions for the HC-SR04 sensor emulator: state codes,
// default timing constants (50 MHz clock) and counter widths.
package emulador_hcsr04_pkg;

  localparam int CICLOS_US_PADRAO   = 50;
  localparam int TRIGGER_MIN_PADRAO = 10 * CICLOS_US_PADRAO;     // 10 us
  localparam int ATRASO_PADRAO      = 400 * CICLOS_US_PADRAO;    // 400 us
  localparam int CICLOS_CM_PADRAO   = 2941;                      // 58.82 us
  localparam int MAX_CM_PADRAO      = 400;
  localparam int TIMEOUT_PADRAO     = 38000 * CICLOS_US_PADRAO;  // 38 ms

  // Counter widths: the shared counter must hold TIMEOUT, the sub-counter
  // CICLOS_CM-1, and the cm counter up to 999.
  localparam int LARG_CNT = 22;
  localparam int LARG_SUB = 12;
  localparam int LARG_CM  = 10;

  typedef enum logic [3:0] {
    ST_INICIAL      = 4'h0,
    ST_MEDE_TRIGGER = 4'h1,
    ST_ATRASO       = 4'h2,
    ST_ECHO         = 4'h3,
    ST_FIM          = 4'h4
  } estado_t;

endpackage

// File: rtl/emulador_hcsr04_if.sv
// Trigger/echo bundle between the measuring circuit (master) and the
// emulated sensor (slave).
interface emulador_hcsr04_if;
  import emulador_hcsr04_pkg::*;

  logic        trigger;
  logic [11:0] distancia;
  logic        echo;
  logic        ocupado;
  logic [7:0]  medidas;
  estado_t     db_estado;

  modport master (
    output trigger, distancia,
    input  echo, ocupado, medidas, db_estado
  );

  modport slave (
    input  trigger, distancia,
    output echo, ocupado, medidas, db_estado
  );
endinterface

// File: rtl/emulador_hcsr04_bcd_para_binario.sv
// Combinational 3-digit BCD to binary converter. Invalid digits (>9) are
// flagged; the binary result is meaningless in that case.
module bcd_para_binario
  import emulador_hcsr04_pkg::*;
(
  input  logic [11:0]         bcd_i,
  output logic [LARG_CM-1:0]  bin_o,
  output logic                digito_invalido_o
);

  // Weighted sum of the three digits; 10 bits cover 999.
  always_comb begin
    bin_o = LARG_CM'(bcd_i[11:8]) * LARG_CM'(100)
          + LARG_CM'(bcd_i[7:4])  * LARG_CM'(10)
          + LARG_CM'(bcd_i[3:0]);
    digito_invalido_o = (bcd_i[11:8] > 4'd9) || (bcd_i[7:4] > 4'd9) ||
                        (bcd_i[3:0] > 4'd9);
  end

endmodule

// File: rtl/emulador_hcsr04.sv
// HC-SR04 sensor emulator: validates the trigger width, waits a fixed
// burst delay and then drives echo for a time proportional to the BCD
// distance (or a fixed timeout when the distance is out of range).
module emulador_hcsr04
  import emulador_hcsr04_pkg::*;
#(
  parameter int TRIGGER_MIN = TRIGGER_MIN_PADRAO,
  parameter int ATRASO      = ATRASO_PADRAO,
  parameter int CICLOS_CM   = CICLOS_CM_PADRAO,
  parameter int MAX_CM      = MAX_CM_PADRAO,
  parameter int TIMEOUT     = TIMEOUT_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  emulador_hcsr04_if.slave   bus
);

  localparam logic [LARG_CNT-1:0] TRIG_MIN_C = LARG_CNT'(TRIGGER_MIN);
  localparam logic [LARG_CNT-1:0] ATRASO_C   = LARG_CNT'(ATRASO);
  localparam logic [LARG_CNT-1:0] TMO_ULT_C  = LARG_CNT'(TIMEOUT - 1);
  localparam logic [LARG_SUB-1:0] SUB_ULT_C  = LARG_SUB'(CICLOS_CM - 1);
  localparam logic [LARG_CM-1:0]  MAX_CM_C   = LARG_CM'(MAX_CM);

  logic                trig_meta_q, trig_s_q, trig_ant_q;
  estado_t             estado_q, estado_d;
  logic [LARG_CNT-1:0] cnt_q, cnt_d;
  logic [LARG_SUB-1:0] sub_q, sub_d;
  logic [LARG_CM-1:0]  cm_q, cm_d;
  logic [11:0]         dist_q, dist_d;
  logic [7:0]          medidas_q, medidas_d;
  logic                echo_q, echo_d;

  logic [LARG_CM-1:0]  dist_bin;
  logic                digito_invalido;
  logic                fora_faixa;
  logic                subida_trig;

  bcd_para_binario u_bcd (
    .bcd_i             (dist_q),
    .bin_o             (dist_bin),
    .digito_invalido_o (digito_invalido)
  );

  assign fora_faixa  = digito_invalido || (dist_bin == '0) || (dist_bin > MAX_CM_C);
  assign subida_trig = trig_s_q && !trig_ant_q;

  // Synchronizer, FSM state and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trig_meta_q <= 1'b0;
      trig_s_q    <= 1'b0;
      trig_ant_q  <= 1'b0;
      estado_q    <= ST_INICIAL;
      cnt_q       <= '0;
      sub_q       <= '0;
      cm_q        <= '0;
      dist_q      <= '0;
      medidas_q   <= '0;
      echo_q      <= 1'b0;
    end else begin
      trig_meta_q <= bus.trigger;
      trig_s_q    <= trig_meta_q;
      trig_ant_q  <= trig_s_q;
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
      cm_q        <= cm_d;
      dist_q      <= dist_d;
      medidas_q   <= medidas_d;
      echo_q      <= echo_d;
    end
  end

  // Next-state and counter control.
  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    sub_d     = sub_q;
    cm_d      = cm_q;
    dist_d    = dist_q;
    medidas_d = medidas_q;
    case (estado_q)
      ST_INICIAL: begin
        // The detection cycle is itself a high cycle, so counting starts
        // at 1: a pulse of exactly TRIGGER_MIN synchronized cycles passes.
        if (subida_trig) begin
          estado_d = ST_MEDE_TRIGGER;
          cnt_d    = LARG_CNT'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_MEDE_TRIGGER: begin
        if (trig_s_q) begin
          if (cnt_q < TRIG_MIN_C) cnt_d = cnt_q + LARG_CNT'(1);
        end else if (cnt_q >= TRIG_MIN_C) begin
          dist_d   = bus.distancia;
          estado_d = ST_ATRASO;
          cnt_d    = '0;
        end else begin
          estado_d = ST_INICIAL;
          cnt_d    = '0;
        end
      end
      ST_ATRASO: begin
        // Counts 0..ATRASO so echo rises ATRASO+1 edges after the fall.
        if (cnt_q == ATRASO_C) begin
          estado_d = ST_ECHO;
          cnt_d    = '0;
          sub_d    = '0;
          cm_d     = dist_bin;
        end else begin
          cnt_d = cnt_q + LARG_CNT'(1);
        end
      end
      ST_ECHO: begin
        if (fora_faixa) begin
          if (cnt_q == TMO_ULT_C) estado_d = ST_FIM;
          else                    cnt_d    = cnt_q + LARG_CNT'(1);
        end else if (sub_q == SUB_ULT_C) begin
          // One centimetre elapsed; stop after the last one.
          if (cm_q <= LARG_CM'(1)) begin
            estado_d = ST_FIM;
          end else begin
            cm_d  = cm_q - LARG_CM'(1);
            sub_d = '0;
          end
        end else begin
          sub_d = sub_q + LARG_SUB'(1);
        end
      end
      ST_FIM: begin
        estado_d  = ST_INICIAL;
        medidas_d = medidas_q + 8'd1;
      end
      default: estado_d = ST_INICIAL;
    endcase
    echo_d = (estado_d == ST_ECHO);
  end

  assign bus.echo      = echo_q;
  assign bus.ocupado   = (estado_q != ST_INICIAL);
  assign bus.medidas   = medidas_q;
  assign bus.db_estado = estado_q;

endmodule

// File: tb/tb_emulador_hcsr04.sv
// Scoreboard bench for emulador_hcsr04 with scaled-down timing constants.
module tb_emulador_hcsr04;

  localparam int TB_TRIGGER_MIN = 8;
  localparam int TB_ATRASO      = 20;
  localparam int TB_CICLOS_CM   = 3;
  localparam int TB_MAX_CM      = 400;
  localparam int TB_TIMEOUT     = 1500;
  // Edge after the trigger fall -> +1 meta, +1 trig_s, +1 edge N, then
  // echo rises ATRASO+1 edges later.
  localparam int LAT_ESP        = TB_ATRASO + 4;
  localparam int LIMITE         = TB_ATRASO + TB_TIMEOUT + 100;

  typedef struct {
    int largura;
    int queda;
    int medidas;
  } esp_t;

  logic clock;
  logic reset;
  emulador_hcsr04_if bus ();

  emulador_hcsr04 #(
    .TRIGGER_MIN (TB_TRIGGER_MIN),
    .ATRASO      (TB_ATRASO),
    .CICLOS_CM   (TB_CICLOS_CM),
    .MAX_CM      (TB_MAX_CM),
    .TIMEOUT     (TB_TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  esp_t fila[$];
  int   n_comp = 0;
  int   n_erro = 0;
  int   n_push = 0;
  int   ciclo  = 0;
  bit   mon_on = 0;
  bit   pend_med = 0;
  int   med_esp = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) ciclo <= ciclo + 1;

  task automatic verifica(input string tag, input longint obs, input longint esp);
    n_comp++;
    if (obs != esp) begin
      n_erro++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  function automatic int largura_esp(input logic [11:0] d);
    int h, t, u, b;
    h = int'(d[11:8]);
    t = int'(d[7:4]);
    u = int'(d[3:0]);
    if (h > 9 || t > 9 || u > 9) return TB_TIMEOUT;
    b = h * 100 + t * 10 + u;
    if (b == 0 || b > TB_MAX_CM) return TB_TIMEOUT;
    return b * TB_CICLOS_CM;
  endfunction

  // Echo monitor: measures each pulse and checks it against the queue head.
  initial begin
    int subida;
    bit eco_ant;
    esp_t e;
    subida  = 0;
    eco_ant = 1'b0;
    forever begin
      @(negedge clock);
      if (!mon_on) begin
        eco_ant  = 1'b0;
        pend_med = 1'b0;
        continue;
      end
      if (bus.echo && !eco_ant) subida = ciclo;
      if (!bus.echo && eco_ant) begin
        if (fila.size() == 0) begin
          verifica("eco_inesperado", 1, 0);
        end else begin
          e = fila.pop_front();
          $display("eco: latencia=%0d largura=%0d esperado=%0d", subida - e.queda,
                   ciclo - subida, e.largura);
          verifica("latencia", subida - e.queda, LAT_ESP);
          verifica("largura", ciclo - subida, e.largura);
          med_esp  = e.medidas;
          pend_med = 1'b1;
        end
      end else if (pend_med) begin
        verifica("medidas", bus.medidas, med_esp);
        pend_med = 1'b0;
      end
      eco_ant = bus.echo;
    end
  end

  task automatic disparo(input logic [11:0] d, input int w, input bit registra);
    esp_t e;
    @(posedge clock);
    #1;
    bus.distancia = d;
    bus.trigger   = 1'b1;
    repeat (w) @(posedge clock);
    #1;
    if (registra) verifica("ocupado_alto", bus.ocupado, 1);
    bus.trigger = 1'b0;
    if (registra) begin
      n_push++;
      e.largura = largura_esp(d);
      e.queda   = ciclo;
      e.medidas = n_push % 256;
      fila.push_back(e);
    end
  endtask

  task automatic aguarda(input int limite);
    int n;
    n = 0;
    while ((fila.size() != 0 || pend_med) && n < limite) begin
      @(negedge clock);
      n++;
    end
    verifica("conclusao", (fila.size() == 0 && !pend_med), 1);
    @(posedge clock);
    #1;
    verifica("ocupado_baixo", bus.ocupado, 0);
  endtask

  task automatic aguarda_eco(input int limite);
    int n;
    n = 0;
    while (!bus.echo && n < limite) begin
      @(negedge clock);
      n++;
    end
    verifica("eco_subiu", bus.echo, 1);
  endtask

  task automatic rejeita(input logic [11:0] d, input int w);
    disparo(d, w, 1'b0);
    repeat (TB_ATRASO + 20) @(posedge clock);
    #1;
    verifica("rejeitado_estado", bus.db_estado, 0);
    verifica("rejeitado_medidas", bus.medidas, n_push % 256);
  endtask

  initial begin
    reset         = 1'b1;
    bus.trigger   = 1'b0;
    bus.distancia = 12'h000;
    repeat (3) @(posedge clock);
    #1;
    verifica("reset_echo", bus.echo, 0);
    verifica("reset_ocupado", bus.ocupado, 0);
    verifica("reset_medidas", bus.medidas, 0);
    verifica("reset_estado", bus.db_estado, 0);
    reset  = 1'b0;
    mon_on = 1'b1;
    repeat (2) @(posedge clock);

    // Nominal measurements.
    disparo(12'h100, TB_TRIGGER_MIN + 2, 1'b1);
    aguarda(LIMITE);
    disparo(12'h075, TB_TRIGGER_MIN + 4, 1'b1);
    aguarda(LIMITE);

    // Trigger width boundary.
    rejeita(12'h001, 5);
    rejeita(12'h001, TB_TRIGGER_MIN - 1);
    disparo(12'h002, TB_TRIGGER_MIN, 1'b1);
    aguarda(LIMITE);

    // Range boundaries and timeouts.
    foreach (fila[i]) verifica("fila_vazia", 0, 1);
    begin
      logic [11:0] faixa [5];
      faixa = '{12'h500, 12'h000, 12'h0A0, 12'h400, 12'h401};
      for (int i = 0; i < 5; i++) begin
        disparo(faixa[i], TB_TRIGGER_MIN, 1'b1);
        aguarda(LIMITE);
      end
    end

    // Trigger and distance changes during ECHO are ignored.
    disparo(12'h100, TB_TRIGGER_MIN + 2, 1'b1);
    aguarda_eco(LIMITE);
    disparo(12'h050, TB_TRIGGER_MIN + 2, 1'b0);
    aguarda(LIMITE);
    disparo(12'h050, TB_TRIGGER_MIN + 2, 1'b1);
    aguarda(LIMITE);

    // Asynchronous reset in the middle of an echo.
    mon_on = 1'b0;
    disparo(12'h100, TB_TRIGGER_MIN, 1'b0);
    aguarda_eco(LIMITE);
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    verifica("reset_assinc_echo", bus.echo, 0);
    verifica("reset_assinc_estado", bus.db_estado, 0);
    verifica("reset_assinc_medidas", bus.medidas, 0);
    @(posedge clock);
    #1;
    reset  = 1'b0;
    n_push = 0;
    repeat (2) @(posedge clock);
    mon_on = 1'b1;

    // 256 measurements wrap the counter back to zero.
    for (int i = 0; i < 256; i++) begin
      disparo(12'h001, TB_TRIGGER_MIN, 1'b1);
      aguarda(LIMITE);
    end
    verifica("medidas_volta", bus.medidas, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_erro);
    $finish;
  end

endmodule
